// File: rtl/qed_dup_ctrl_if.sv
// Handshake bundle between fetch, the QED queue and the dup controller.
// master drives fetch/queue status, slave is the controller.
interface qed_dup_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             ena;
    logic             force_dup;
    logic             IF_stall;
    logic [31:0]      ifu_qed_instr;
    logic             qic_vld;
    logic             exec_dup;
    logic [CNT_W-1:0] occ_cnt;
    logic             qed_sync;
    logic             proto_err;

    modport master (
        output ena, force_dup, IF_stall, ifu_qed_instr, qic_vld,
        input  exec_dup, occ_cnt, qed_sync, proto_err
    );

    modport slave (
        input  ena, force_dup, IF_stall, ifu_qed_instr, qic_vld,
        output exec_dup, occ_cnt, qed_sync, proto_err
    );
endinterface

// File: rtl/qed_dup_ctrl.sv
// QED original/duplicate mode controller: mirrors queue occupancy,
// switches to replay, pulses sync and flags queue protocol errors.
module qed_dup_ctrl #(
    parameter int DEPTH     = 64,
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = 6
) (
    input logic          clk,
    input logic          rst,
    qed_dup_ctrl_if.slave qif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ORIG = 2'd1,
        DUP  = 2'd2
    } state_t;

    localparam logic [CNT_W:0] FULL_C = (CNT_W+1)'(DEPTH - 1);
    localparam logic [CNT_W:0] THR_C  = (CNT_W+1)'(THRESHOLD);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] occ_nxt;
    logic [CNT_W:0]   cnt_ins;
    logic             sync_q;
    logic             err_q;
    logic             nop;
    logic             full;
    logic             empty;
    logic             ins;
    logic             del;
    logic             to_dup;
    logic             last;
    logic             err_now;
    logic             unused_instr;

    assign unused_instr = ^qif.ifu_qed_instr[31:7];

    always_comb begin
        nop     = qif.ifu_qed_instr[6:0] == 7'h7F;
        full    = {1'b0, occ} == FULL_C;
        empty   = occ == '0;
        ins     = (state == ORIG) & ~qif.IF_stall & ~nop & ~full;
        del     = (state == DUP) & ~qif.IF_stall & ~empty;
        cnt_ins = {1'b0, occ} + {{CNT_W{1'b0}}, ins};
        to_dup  = (cnt_ins == THR_C) | (cnt_ins == FULL_C) |
                  ((qif.force_dup | ~qif.ena) & (cnt_ins != '0));
        last    = del & (occ == CNT_W'(1));
        occ_nxt = occ;
        err_now = qif.qic_vld;
        unique case (state)
            ORIG: begin
                occ_nxt = cnt_ins[CNT_W-1:0];
                err_now = qif.qic_vld != ins;
            end
            DUP: begin
                occ_nxt = occ - {{(CNT_W-1){1'b0}}, del};
                err_now = qif.qic_vld != del;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A started replay always runs to empty; ena/force_dup only matter in ORIG.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (qif.ena) state_nxt = ORIG;
            ORIG: begin
                if (to_dup)        state_nxt = DUP;
                else if (~qif.ena) state_nxt = IDLE;
            end
            DUP: if (last) state_nxt = qif.ena ? ORIG : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= '0;
            sync_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            occ    <= occ_nxt;
            sync_q <= last;
            if (err_now) err_q <= 1'b1;
        end
    end

    always_comb begin
        qif.exec_dup  = state == DUP;
        qif.occ_cnt   = occ;
        qif.qed_sync  = sync_q;
        qif.proto_err = err_q;
    end

endmodule
